// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
// Optional ack handshake is built when RST_SEQ_ACK_EN is defined.
package rst_seq_pkg;

  localparam int N_DOM_DEF    = 4;
  localparam int HOLD_CYC_DEF = 8;
  localparam int GAP_CYC_DEF  = 16;
  localparam int ACK_TMO_DEF  = 255;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_GAP      = 3'd1,
    ST_REL      = 3'd2,
`ifdef RST_SEQ_ACK_EN
    ST_WAIT_ACK = 3'd3,
`endif
    ST_IDLE     = 3'd4
  } state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on clk.
// Ports: clk, rst_async_n (in), rst_sync_n (out, synchronized release).
module rst_sync (
  input  logic clk,
  input  logic rst_async_n,
  output logic rst_sync_n
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) ff_q <= '0;
    else              ff_q <= {ff_q[0], 1'b1};
  end

  assign rst_sync_n = ff_q[1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds domains in reset, then releases them in order.
// Ports: clk, rst_async_n, sw_rst_req, sw_rst_mask, dom_ack (in);
//        dom_rst_n, seq_busy, seq_done, timeout_err (out).
// Macro RST_SEQ_ACK_EN adds per-domain ack wait with timeout.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_DOM    = N_DOM_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF,
  parameter int ACK_TMO  = ACK_TMO_DEF
) (
  input  logic             clk,
  input  logic             rst_async_n,
  input  logic             sw_rst_req,
  input  logic [N_DOM-1:0] sw_rst_mask,
  input  logic [N_DOM-1:0] dom_ack,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             timeout_err
);

`ifdef RST_SEQ_ACK_EN
  localparam int CMAX = max3(HOLD_CYC, GAP_CYC, ACK_TMO);
`else
  localparam int CMAX = max3(HOLD_CYC, GAP_CYC, 0);
`endif
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
`ifdef RST_SEQ_ACK_EN
  localparam logic [CW-1:0] TMO_LAST  = CW'(ACK_TMO - 1);
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_DOM-1:0] mask_q, mask_d;
  logic [N_DOM-1:0] dom_q, dom_d;
  logic             done_q, done_d;
  logic             sync_n;

  logic             adv;
  logic             nxt_found;
  logic [IW-1:0]    nxt_idx;
  int               base;

  rst_sync u_rst_sync (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .rst_sync_n  (sync_n)
  );

  // Next targeted index at or after base; untargeted ones
  // are skipped without spending any GAP time.
  always_comb begin
    base      = (state_q == ST_HOLD) ? 0 : int'(idx_q) + 1;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= base)) begin
        nxt_found = 1'b1;
        nxt_idx   = IW'(i);
      end
    end
  end

`ifdef RST_SEQ_ACK_EN
  logic err_q, err_d;
`else
  logic unused_ack;
  assign unused_ack = ^dom_ack;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    mask_d  = mask_q;
    dom_d   = dom_q;
    adv     = 1'b0;
`ifdef RST_SEQ_ACK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_HOLD: begin
        // hold count only starts once the release is synchronized
        if (!sync_n)                cnt_d = '0;
        else if (cnt_q == HOLD_LAST) adv  = 1'b1;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_REL;
          cnt_d   = '0;
        end
      end
      ST_REL: begin
        dom_d[idx_q] = 1'b1;
`ifdef RST_SEQ_ACK_EN
        state_d = ST_WAIT_ACK;
        cnt_d   = '0;
`else
        adv     = 1'b1;
`endif
      end
`ifdef RST_SEQ_ACK_EN
      ST_WAIT_ACK: begin
        if (dom_ack[idx_q]) begin
          adv = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end
      end
`endif
      ST_IDLE: begin
        cnt_d = '0;
        if (sw_rst_req && (|sw_rst_mask)) begin
          state_d = ST_HOLD;
          mask_d  = sw_rst_mask;
          idx_d   = '0;
          dom_d   = dom_q & ~sw_rst_mask;
`ifdef RST_SEQ_ACK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (adv) begin
      cnt_d = '0;
      if (nxt_found) begin
        state_d = ST_GAP;
        idx_d   = nxt_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end

    done_d = (state_d == ST_IDLE) && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '1;
      dom_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
    end
  end

`ifdef RST_SEQ_ACK_EN
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) err_q <= 1'b0;
    else              err_q <= err_d;
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign dom_rst_n = dom_q;
  assign seq_busy  = (state_q != ST_IDLE);
  assign seq_done  = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl.
// Release events are checked against a queue of expected values/spacing.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 16;
  localparam int TMO  = 255;
`ifdef RST_SEQ_ACK_EN
  localparam int AE = 1;
`else
  localparam int AE = 0;
`endif
  localparam int STEP    = GAP + 1 + AE;
  localparam int FIRST   = 2 + HOLD + GAP + 1;
  localparam int SWFIRST = HOLD + GAP + 1;

  typedef struct {
    logic [N-1:0] val;
    int           gap;
  } exp_t;

  logic         clk;
  logic         rst_async_n;
  logic         sw_rst_req;
  logic [N-1:0] sw_rst_mask;
  logic [N-1:0] dom_ack;
  logic [N-1:0] dom_rst_n;
  logic         seq_busy;
  logic         seq_done;
  logic         timeout_err;

  exp_t         exp_q[$];
  int           checks   = 0;
  int           errors   = 0;
  int           cyc      = 0;
  int           last_cyc = 0;
  int           done_cnt = 0;
  logic [N-1:0] prev_dom = '0;

  rst_seq_ctrl #(
    .N_DOM    (N),
    .HOLD_CYC (HOLD),
    .GAP_CYC  (GAP),
    .ACK_TMO  (TMO)
  ) dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_mask (sw_rst_mask),
    .dom_ack     (dom_ack),
    .dom_rst_n   (dom_rst_n),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: every change of dom_rst_n pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (seq_done) done_cnt++;
    if (dom_rst_n !== prev_dom) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%b at cyc %0d", dom_rst_n, cyc);
      end else begin
        e = exp_q.pop_front();
        if (dom_rst_n !== e.val) begin
          errors++;
          $display("FAIL sb_value got=%b exp=%b", dom_rst_n, e.val);
        end
        if (e.gap >= 0) begin
          checks++;
          if (cyc - last_cyc != e.gap) begin
            errors++;
            $display("FAIL sb_gap val=%b got=%0d exp=%0d",
                     e.val, cyc - last_cyc, e.gap);
          end
        end
      end
      prev_dom = dom_rst_n;
      last_cyc = cyc;
    end
  end

`ifndef RST_SEQ_ACK_EN
  initial begin
    forever begin
      @(posedge clk);
      #1 dom_ack = N'($urandom);
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic push(input logic [N-1:0] v, input int g);
    exp_t e;
    e.val = v;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic pulse_req(input logic [N-1:0] m);
    @(posedge clk);
    #1 sw_rst_req = 1'b1;
    sw_rst_mask = m;
    @(posedge clk);
    #1 sw_rst_req = 1'b0;
    sw_rst_mask = '0;
  endtask

  task automatic wait_q_empty(input string nm, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d exp=0", nm, exp_q.size());
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int s = done_cnt;
    int n = 0;
    while (done_cnt == s && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (done_cnt != s + 1) begin
      errors++;
      $display("FAIL %s done_pulses got=%0d exp=1", nm, done_cnt - s);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d exp=0", nm, exp_q.size());
    end
    checks++;
    if (seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got=%b exp=0", nm, seq_busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (dom_rst_n !== '0) begin
      errors++;
      $display("FAIL rst_dom got=%b exp=0000", dom_rst_n);
    end
    checks++;
    if (seq_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy got=%b exp=1", seq_busy);
    end
    checks++;
    if (seq_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b exp=0", seq_done);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got=%b exp=0", timeout_err);
    end
  endtask

  task automatic test_power_on();
    push(4'b0001, FIRST);
    push(4'b0011, STEP);
    push(4'b0111, STEP);
    push(4'b1111, STEP);
    @(negedge clk);
    last_cyc    = cyc;
    rst_async_n = 1'b1;
    wait_done("pwr_done", 300);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL pwr_err got=%b exp=0", timeout_err);
    end
  endtask

  task automatic test_sw_mask();
    push(4'b0101, -1);
    push(4'b0111, SWFIRST);
    push(4'b1111, STEP);
    pulse_req(4'b1010);
    checks++;
    if (dom_rst_n !== 4'b0101) begin
      errors++;
      $display("FAIL sw_drop got=%b exp=0101", dom_rst_n);
    end
    checks++;
    if (seq_busy !== 1'b1) begin
      errors++;
      $display("FAIL sw_busy got=%b exp=1", seq_busy);
    end
    repeat (3) @(posedge clk);
    pulse_req(4'b0001);
    checks++;
    if (dom_rst_n !== 4'b0101) begin
      errors++;
      $display("FAIL busy_ignore got=%b exp=0101", dom_rst_n);
    end
    wait_done("sw_done", 300);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL sw_err got=%b exp=0", timeout_err);
    end
  endtask

  task automatic test_ignore_idle();
    int s = done_cnt;
    pulse_req(4'b0000);
    checks++;
    if (seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL zmask_busy got=%b exp=0", seq_busy);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (dom_rst_n !== 4'b1111) begin
      errors++;
      $display("FAIL zmask_dom got=%b exp=1111", dom_rst_n);
    end
    checks++;
    if (done_cnt != s || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL zmask_state done=%0d busy=%b exp=0/0",
               done_cnt - s, seq_busy);
    end
  endtask

  task automatic test_reset_mid();
    push(4'b0000, -1);
    @(posedge clk);
    #2 rst_async_n = 1'b0;
    #1;
    checks++;
    if (dom_rst_n !== '0 || seq_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle got=%b/%b exp=0000/1", dom_rst_n, seq_busy);
    end
    repeat (3) @(negedge clk);
    push(4'b0001, FIRST);
    push(4'b0011, STEP);
    last_cyc    = cyc;
    rst_async_n = 1'b1;
    wait_q_empty("mid_pre", 200);
    repeat (5) @(posedge clk);
    push(4'b0000, -1);
    #2 rst_async_n = 1'b0;
    #1;
    checks++;
    if (dom_rst_n !== '0) begin
      errors++;
      $display("FAIL mid_dom got=%b exp=0000", dom_rst_n);
    end
    checks++;
    if (seq_busy !== 1'b1 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_flags got=%b%b exp=10", seq_busy, seq_done);
    end
    repeat (3) @(negedge clk);
    push(4'b0001, FIRST);
    push(4'b0011, STEP);
    push(4'b0111, STEP);
    push(4'b1111, STEP);
    last_cyc    = cyc;
    rst_async_n = 1'b1;
    wait_done("mid_done", 300);
  endtask

`ifdef RST_SEQ_ACK_EN
  task automatic test_timeout();
    int rel = 0;
    int n   = 0;
    dom_ack = 4'b1011;
    push(4'b0000, -1);
    push(4'b0001, SWFIRST);
    push(4'b0011, STEP);
    push(4'b0111, STEP);
    push(4'b1111, TMO + GAP + 1);
    pulse_req(4'b1111);
    while (dom_rst_n !== 4'b0111 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rel = cyc;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early got=%b exp=0", timeout_err);
    end
    n = 0;
    while (timeout_err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc - rel != TMO) begin
      errors++;
      $display("FAIL tmo_time got=%0d exp=%0d", cyc - rel, TMO);
    end
    wait_done("tmo_done", 100);
    dom_ack = 4'b1111;
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky got=%b exp=1", timeout_err);
    end
    push(4'b1110, -1);
    push(4'b1111, SWFIRST);
    pulse_req(4'b0001);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear got=%b exp=0", timeout_err);
    end
    wait_done("tmo_done2", 100);
  endtask
`endif

  initial begin
    rst_async_n = 1'b0;
    sw_rst_req  = 1'b0;
    sw_rst_mask = '0;
    dom_ack     = '1;
    test_reset();
    test_power_on();
    test_sw_mask();
    test_ignore_idle();
    test_reset_mid();
`ifdef RST_SEQ_ACK_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
